// File: rtl/simple_cpu_core.sv
// Single-cycle 32-bit CPU core: opcode decoder, 32x32 register file and an
// 8-function ALU with operand and writeback multiplexers.
module simple_cpu_core (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [18:0] INSTRUCTION,
  output logic [31:0] PC,
  input  logic [4:0]  DBG_ADDR,
  output logic [31:0] DBG_DATA
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_AND  = 4'h2,
    OP_OR   = 4'h3,
    OP_XOR  = 4'h4,
    OP_SLL  = 4'h5,
    OP_SRL  = 4'h6,
    OP_ADDI = 4'h7,
    OP_MOVI = 4'h8,
    OP_MOV  = 4'h9,
    OP_BEQZ = 4'hA,
    OP_BNEZ = 4'hB,
    OP_JMP  = 4'hC
  } op_e;

  typedef enum logic [2:0] {
    ALU_PASSB = 3'b000,
    ALU_ADD   = 3'b001,
    ALU_SUB   = 3'b010,
    ALU_AND   = 3'b011,
    ALU_OR    = 3'b100,
    ALU_XOR   = 3'b101,
    ALU_SLL   = 3'b110,
    ALU_SRL   = 3'b111
  } aluop_e;

  typedef enum logic [1:0] {
    BR_NONE,
    BR_EQZ,
    BR_NEZ,
    BR_ALWAYS
  } br_e;

  logic [31:0] regs_q [32];
  logic [31:0] pc_q, pc_d;

  logic [3:0]  op;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm5, imm10, boff;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_res, wb_val;

  aluop_e alu_op;
  br_e    br_type;
  logic   we, imm_sel, mov_sel, taken;

  assign op    = INSTRUCTION[18:15];
  assign rd    = INSTRUCTION[14:10];
  assign rs1   = INSTRUCTION[9:5];
  assign rs2   = INSTRUCTION[4:0];
  assign imm5  = {{27{INSTRUCTION[4]}}, INSTRUCTION[4:0]};
  assign imm10 = {{22{INSTRUCTION[9]}}, INSTRUCTION[9:0]};
  // Branch offset reuses the rd and rs2 fields; rs1 stays free for the test operand.
  assign boff  = {{22{INSTRUCTION[14]}}, INSTRUCTION[14:10], INSTRUCTION[4:0]};

  always_comb begin
    alu_op  = ALU_PASSB;
    we      = 1'b0;
    imm_sel = 1'b0;
    mov_sel = 1'b0;
    br_type = BR_NONE;
    case (op)
      OP_ADD:  begin alu_op = ALU_ADD; we = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; we = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; we = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  we = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR; we = 1'b1; end
      OP_SLL:  begin alu_op = ALU_SLL; we = 1'b1; end
      OP_SRL:  begin alu_op = ALU_SRL; we = 1'b1; end
      OP_ADDI: begin alu_op = ALU_ADD; we = 1'b1; imm_sel = 1'b1; end
      OP_MOVI: begin we = 1'b1; mov_sel = 1'b1; end
      OP_MOV:  begin alu_op = ALU_PASSB; we = 1'b1; end
      OP_BEQZ: br_type = BR_EQZ;
      OP_BNEZ: br_type = BR_NEZ;
      OP_JMP:  br_type = BR_ALWAYS;
      default: ;
    endcase
  end

  assign rs1_val = regs_q[rs1];
  assign rs2_val = regs_q[rs2];
  assign alu_b   = imm_sel ? imm5 : rs2_val;

  always_comb begin
    alu_res = '0;
    case (alu_op)
      ALU_PASSB: alu_res = alu_b;
      ALU_ADD:   alu_res = rs1_val + alu_b;
      ALU_SUB:   alu_res = rs1_val - alu_b;
      ALU_AND:   alu_res = rs1_val & alu_b;
      ALU_OR:    alu_res = rs1_val | alu_b;
      ALU_XOR:   alu_res = rs1_val ^ alu_b;
      ALU_SLL:   alu_res = rs1_val << alu_b[4:0];
      ALU_SRL:   alu_res = rs1_val >> alu_b[4:0];
      default:   alu_res = '0;
    endcase
  end

  assign wb_val = mov_sel ? imm10 : alu_res;

  always_comb begin
    taken = 1'b0;
    case (br_type)
      BR_EQZ:    taken = (rs1_val == '0);
      BR_NEZ:    taken = (rs1_val != '0);
      BR_ALWAYS: taken = 1'b1;
      default:   taken = 1'b0;
    endcase
  end

  assign pc_d = taken ? (pc_q + boff) : (pc_q + 32'd1);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q <= '0;
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      pc_q <= pc_d;
      if (we) begin
        regs_q[rd] <= wb_val;
      end
    end
  end

  assign PC       = pc_q;
  assign DBG_DATA = regs_q[DBG_ADDR];

endmodule

// File: tb/tb_simple_cpu_core.sv
// Scoreboard bench for simple_cpu_core: expected register/PC values are queued
// as each instruction is driven and compared once the clock edge retires it.
module tb_simple_cpu_core;

  logic        CLK;
  logic        RESET;
  logic [18:0] INSTRUCTION;
  logic [31:0] PC;
  logic [4:0]  DBG_ADDR;
  logic [31:0] DBG_DATA;

  simple_cpu_core dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .INSTRUCTION (INSTRUCTION),
    .PC          (PC),
    .DBG_ADDR    (DBG_ADDR),
    .DBG_DATA    (DBG_DATA)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        is_pc;
    logic [4:0]  addr;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  localparam logic [18:0] NOP = {4'hD, 15'h0};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  function automatic logic [18:0] enc_r(input logic [3:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2};
  endfunction

  function automatic logic [18:0] enc_movi(input logic [4:0] rd, input logic [9:0] imm);
    return {4'h8, rd, imm};
  endfunction

  function automatic logic [18:0] enc_br(input logic [3:0] op, input logic [4:0] rs1,
                                         input logic [9:0] off);
    return {op, off[9:5], rs1, off[4:0]};
  endfunction

  task automatic exp_reg(input logic [4:0] a, input logic [31:0] v);
    exp_q.push_back('{is_pc: 1'b0, addr: a, val: v});
  endtask

  task automatic exp_pc(input logic [31:0] v);
    exp_q.push_back('{is_pc: 1'b1, addr: 5'd0, val: v});
  endtask

  task automatic drain();
    exp_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.is_pc) begin
        check_eq("pc", PC, e.val);
      end else begin
        DBG_ADDR = e.addr;
        #1;
        check_eq($sformatf("r%0d", e.addr), DBG_DATA, e.val);
      end
    end
  endtask

  // Drive one instruction, retire it on the next edge, then compare queued results.
  task automatic step(input logic [18:0] instr);
    INSTRUCTION = instr;
    @(posedge CLK);
    #1;
    drain();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    INSTRUCTION = enc_movi(5'd5, 10'h155);
    repeat (2) @(posedge CLK);
    #1;
    drain();
    RESET = 1'b0;
  endtask

  task automatic setup_pc6();
    do_reset();
    step(enc_movi(5'd13, 10'd7));
    repeat (5) step(NOP);
  endtask

  initial begin
    RESET = 1'b1;
    INSTRUCTION = NOP;
    DBG_ADDR = '0;

    // Reset: PC and every register cleared, writeback suppressed under reset.
    RESET = 1'b1;
    INSTRUCTION = enc_movi(5'd5, 10'h155);
    repeat (2) @(posedge CLK);
    #1;
    exp_pc(32'd0);
    for (int i = 0; i < 32; i++) exp_reg(5'(i), 32'd0);
    drain();
    RESET = 1'b0;

    // MOVI and ADD
    exp_reg(5'd1, 32'd5);                 step(enc_movi(5'd1, 10'd5));
    exp_reg(5'd2, 32'hFFFF_FFFD);         step(enc_movi(5'd2, 10'h3FD));
    exp_reg(5'd3, 32'd2); exp_pc(32'd3);  step(enc_r(4'h0, 5'd3, 5'd1, 5'd2));

    // ALU ops
    exp_reg(5'd1, 32'h0F0);               step(enc_movi(5'd1, 10'h0F0));
    exp_reg(5'd2, 32'h0FF);               step(enc_movi(5'd2, 10'h0FF));
    exp_reg(5'd5, 32'hFFFF_FFF1);         step(enc_r(4'h1, 5'd5, 5'd1, 5'd2));
    exp_reg(5'd6, 32'h0F0);               step(enc_r(4'h2, 5'd6, 5'd1, 5'd2));
    exp_reg(5'd7, 32'h0FF);               step(enc_r(4'h3, 5'd7, 5'd1, 5'd2));
    exp_reg(5'd8, 32'h00F);               step(enc_r(4'h4, 5'd8, 5'd1, 5'd2));
    exp_reg(5'd2, 32'd4);                 step(enc_movi(5'd2, 10'd4));
    exp_reg(5'd9, 32'hF00);               step(enc_r(4'h5, 5'd9, 5'd1, 5'd2));
    exp_reg(5'd10, 32'h00F);              step(enc_r(4'h6, 5'd10, 5'd1, 5'd2));
    exp_reg(5'd11, 32'd4); exp_reg(5'd1, 32'h0F0);
    step(enc_r(4'h9, 5'd11, 5'd1, 5'd2));

    // ADDI sign extension, and R0 as an ordinary register
    exp_reg(5'd1, 32'd5);                 step(enc_movi(5'd1, 10'd5));
    exp_reg(5'd4, 32'd4);                 step(enc_r(4'h7, 5'd4, 5'd1, 5'h1F));
    exp_reg(5'd12, 32'd8);                step(enc_r(4'h7, 5'd12, 5'd1, 5'd3));
    exp_reg(5'd0, 32'd9); exp_pc(32'd17); step(enc_movi(5'd0, 10'd9));

    // Read-during-write: old value visible until the edge
    INSTRUCTION = enc_movi(5'd0, 10'd21);
    DBG_ADDR = 5'd0;
    #1;
    check_eq("r0_before_edge", DBG_DATA, 32'd9);
    exp_reg(5'd0, 32'd21);
    step(enc_movi(5'd0, 10'd21));

    // Branches
    setup_pc6();
    exp_pc(32'd10); exp_reg(5'd13, 32'd7); exp_reg(5'd0, 32'd0);
    step(enc_br(4'hA, 5'd0, 10'd4));
    setup_pc6();
    exp_pc(32'd7); exp_reg(5'd13, 32'd7); exp_reg(5'd0, 32'd0);
    step(enc_br(4'hA, 5'd13, 10'd4));
    setup_pc6();
    exp_pc(32'd4); exp_reg(5'd13, 32'd7); exp_reg(5'd0, 32'd0);
    step(enc_br(4'hB, 5'd13, 10'h3FE));
    setup_pc6();
    exp_pc(32'd7); exp_reg(5'd0, 32'd0);
    step(enc_br(4'hB, 5'd0, 10'h3FE));

    // JMP backwards from 0 wraps; NOP at the top wraps back to 0
    do_reset();
    exp_pc(32'hFFFF_FFFF);                step(enc_br(4'hC, 5'd0, 10'h3FF));
    exp_pc(32'd0); exp_reg(5'd0, 32'd0);  step(enc_r(4'hF, 5'd0, 5'd0, 5'd5));

    // Reset asserted alongside ADD r3 overrides writeback and PC update
    do_reset();
    exp_reg(5'd1, 32'd5);                 step(enc_movi(5'd1, 10'd5));
    exp_reg(5'd2, 32'd6);                 step(enc_movi(5'd2, 10'd6));
    RESET = 1'b1;
    exp_pc(32'd0); exp_reg(5'd3, 32'd0); exp_reg(5'd1, 32'd0);
    step(enc_r(4'h0, 5'd3, 5'd1, 5'd2));
    RESET = 1'b0;
    exp_pc(32'd1); exp_reg(5'd3, 32'd0);  step(enc_r(4'h0, 5'd3, 5'd1, 5'd2));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/simple_cpu_core.md
Name: simple_cpu_core

Overview:
- Single-cycle 32-bit CPU core built from three parts:
  - an opcode decoder (control unit),
  - a 32x32 register file,
  - an 8-function ALU with operand/result multiplexers.
- Each cycle it executes the 19-bit INSTRUCTION fetched externally at address PC, writes the result back and updates PC.
- Sits between an external instruction ROM (addressed by PC) and the test harness.

Parameters:
- none (data width fixed at 32, 32 registers, 19-bit instruction)

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- INSTRUCTION  input  19  instruction at current PC
- PC  output  32  program counter (registered)
- DBG_ADDR  input  5  debug register-read address
- DBG_DATA  output  32  combinational read of register[DBG_ADDR]

Behaviour:
- Clock and reset: clock CLK; reset RESET, synchronous, active-high.
- On a rising edge with RESET=1:
  - PC <= 0.
  - All 32 registers <= 0.
  - No writeback occurs.
- Instruction fields:
  - op=[18:15], rd=[14:10], rs1=[9:5], rs2=[4:0].
  - imm5 = sext([4:0]).
  - imm10 = sext([9:0]).
  - boff = sext({[14:10],[4:0]}), a 10-bit offset.
- Register file:
  - Reads of R[rs1], R[rs2] and R[DBG_ADDR] are combinational.
  - Write of R[rd] happens at the rising edge when WE=1.
  - R0 is an ordinary writable register.
  - Read-during-write returns the old value until the edge.
- ALU (3-bit ALUOP, operands A and B, modulo 2^32, no flags):
  - 000 pass B
  - 001 A+B
  - 010 A-B
  - 011 A&B
  - 100 A|B
  - 101 A^B
  - 110 A<<B[4:0] (logical)
  - 111 A>>B[4:0] (logical)
- Operand and writeback muxes:
  - B-mux: IMM_SELECT=1 selects imm5, else R[rs2].
  - Writeback mux: MOV_SELECT=1 selects imm10, else ALU result.
- Decode table (ALUOP / WE / IMM_SELECT / MOV_SELECT / branch type):
  - 0000 ADD rd=rs1+rs2: 001/1/0/0/none
  - 0001 SUB rd=rs1-rs2: 010/1/0/0/none
  - 0010 AND: 011/1/0/0/none
  - 0011 OR: 100/1/0/0/none
  - 0100 XOR: 101/1/0/0/none
  - 0101 SLL: 110/1/0/0/none
  - 0110 SRL: 111/1/0/0/none
  - 0111 ADDI rd=rs1+imm5: 001/1/1/0/none
  - 1000 MOVI rd=imm10: x/1/x/1/none
  - 1001 MOV rd=rs2: 000/1/0/0/none
  - 1010 BEQZ: WE=0; taken if R[rs1]==0
  - 1011 BNEZ: WE=0; taken if R[rs1]!=0
  - 1100 JMP: WE=0; always taken
  - 1101-1111 NOP: WE=0; PC+1
- Next PC:
  - Taken branch/jump: PC+boff (wraps modulo 2^32).
  - Otherwise: PC+1.
  - Applied at the rising edge when RESET=0.
- Latency: one instruction per cycle; result is visible on DBG_DATA right after the edge.
- Control outputs are pure combinational functions of op.
- Unknown opcodes behave as NOP.
- RESET asserted mid-program overrides any pending write and branch in that cycle.

Test Plan:
- Reset:
  - Stimulus: RESET=1 for 2 edges with arbitrary INSTRUCTION.
  - Required: PC=0; DBG_DATA=0 for all 32 addresses.
- MOVI and ADD:
  - Stimulus: MOVI r1,5; MOVI r2,-3; ADD r3,r1,r2.
  - Required: r1=5, r2=0xFFFFFFFD, r3=2; PC=3.
- ALU ops:
  - Stimulus: r1=0x0F0, r2=0x0FF; SUB, AND, OR, XOR, SLL with r2=4, SRL with r2=4, MOV.
  - Required: 0xFFFFFFF1, 0x0F0, 0x0FF, 0x00F, 0xF00, 0x00F, rs2 value.
- ADDI sign extension:
  - Stimulus: ADDI r4,r1,imm5=0x1F with r1=5.
  - Required: r4=4.
- Branches:
  - BEQZ with R[rs1]=0, boff=4 at PC=6 -> PC=10.
  - BEQZ with R[rs1]=7 -> PC=7.
  - BNEZ with R[rs1]=7, boff=-2 at PC=6 -> PC=4.
  - All three: no register changes.
- JMP:
  - Stimulus: JMP boff=-1 at PC=0.
  - Required: PC=0xFFFFFFFF.
- Reset mid-program:
  - Stimulus: RESET asserted alongside ADD r3.
  - Required: r3 not written; PC=0 next cycle.
